rice_bus_arbiter: RTL and testbench

Shares one downstream rice bus slave port between MASTERS upstream rice bus masters, for example instruction fetch and load/store sharing a single memory port. It arbitrates requests round-robin. A grant is locked while a request is stalled. An in-order ID FIFO records the owner of each outstanding request, so each response goes back to the master that issued it. There is zero added latency on both the request and response paths.

---
 rtl/rice_bus_arbiter_if.sv | 30 +++
 rtl/rice_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_rice_bus_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rice_bus_arbiter_if.sv
// Rice bus bundle. LANES=MASTERS on the upstream side, LANES=1 on the slave side.
// The response payload (read_data/error) is a single broadcast lane regardless of LANES.
interface rice_bus_arbiter_if #(
  parameter int LANES         = 1,
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64
);
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  logic [LANES-1:0]               request_valid;
  logic [LANES-1:0]               request_ready;
  logic [LANES-1:0]               write;
  logic [LANES*ADDRESS_WIDTH-1:0] address;
  logic [LANES*STROBE_WIDTH-1:0]  strobe;
  logic [LANES*DATA_WIDTH-1:0]    write_data;
  logic [LANES-1:0]               response_valid;
  logic [LANES-1:0]               response_ready;
  logic [DATA_WIDTH-1:0]          read_data;
  logic                           error;

  modport master (
    output request_valid, write, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, write, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_bus_arbiter.sv
// Round-robin arbiter sharing one rice bus slave between MASTERS masters.
// Grants are locked while a forwarded request stalls; an in-order ID FIFO
// steers each response back to the master that issued the request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OPEN   | round-robin scan from the pointer picks the candidate
// ST_LOCKED | a forwarded request stalled; candidate pinned to lock_idx_q
module rice_bus_arbiter #(
  parameter int MASTERS         = 2,
  parameter int ADDRESS_WIDTH   = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                i_clk,
  input logic                i_rst_n,
  rice_bus_arbiter_if.slave  up,
  rice_bus_arbiter_if.master dn
);
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   lock_idx_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   cand_idx;
  logic            cand_found;
  logic            fwd;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IW-1:0]   head;
  logic [IW-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign fwd        = i_rst_n & cand_found & ~fifo_full;
  assign accept     = fwd & dn.request_ready[0];
  assign pop        = dn.response_valid[0] & dn.response_ready[0];
  assign head       = fifo_mem[rd_ptr_q];

  // Lock state register; the lock index tracks the candidate until the lock engages.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_OPEN;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_OPEN) lock_idx_q <= cand_idx;
    end
  end

  // Lock engages on a stalled forward and releases on accept or a dropped request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:   if (fwd && !dn.request_ready[0]) state_d = ST_LOCKED;
      ST_LOCKED: if (accept || !up.request_valid[lock_idx_q]) state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  // Candidate selection and request-path outputs.
  always_comb begin
    int idx;
    idx           = 0;
    cand_found    = 1'b0;
    cand_idx      = '0;
    if (state_q == ST_LOCKED) begin
      cand_idx   = lock_idx_q;
      cand_found = up.request_valid[lock_idx_q];
    end else begin
      for (int off = 0; off < MASTERS; off++) begin
        idx = (int'(ptr_q) + off) % MASTERS;
        if (!cand_found && up.request_valid[idx]) begin
          cand_found = 1'b1;
          cand_idx   = IW'(idx);
        end
      end
    end

    dn.request_valid = fwd;
    dn.write         = '0;
    dn.address       = '0;
    dn.strobe        = '0;
    dn.write_data    = '0;
    if (cand_found) begin
      dn.write      = up.write[cand_idx];
      dn.address    = up.address[cand_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      dn.strobe     = up.strobe[cand_idx*STROBE_WIDTH +: STROBE_WIDTH];
      dn.write_data = up.write_data[cand_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    up.request_ready = '0;
    if (accept) up.request_ready[cand_idx] = 1'b1;
  end

  // Response routing straight from the FIFO head, no added latency.
  always_comb begin
    up.response_valid = '0;
    if (i_rst_n && dn.response_valid[0] && !fifo_empty) up.response_valid[head] = 1'b1;
    dn.response_ready = i_rst_n & ~fifo_empty & up.response_ready[head];
    up.read_data      = dn.read_data;
    up.error          = dn.error;
  end

  // Round-robin pointer moves past the master that was just accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (cand_idx == IW'(MASTERS - 1)) ? '0 : cand_idx + 1'b1;
    end
  end

  // In-order owner FIFO: push granted index on accept, pop on response handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr_q] <= cand_idx;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed bench for rice_bus_arbiter with MASTERS=2, MAX_OUTSTANDING=4.
module tb_rice_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  rice_bus_arbiter_if #(.LANES(2), .ADDRESS_WIDTH(64), .DATA_WIDTH(64)) up ();
  rice_bus_arbiter_if #(.LANES(1), .ADDRESS_WIDTH(64), .DATA_WIDTH(64)) dn ();

  rice_bus_arbiter #(
    .MASTERS(2), .ADDRESS_WIDTH(64), .DATA_WIDTH(64), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .up      (up),
    .dn      (dn)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    up.request_valid  = 2'b11;
    up.write          = 2'b00;
    up.address        = {64'h2000, 64'h1000};
    up.strobe         = {8'hF0, 8'h0F};
    up.write_data     = {64'hBBBB, 64'hAAAA};
    up.response_ready = 2'b11;
    dn.request_ready  = 1'b1;
    dn.response_valid = 1'b1;
    dn.read_data      = 64'h0;
    dn.error          = 1'b0;

    // reset holds all handshake outputs low
    #1;
    chk("rst_req_valid", dn.request_valid, 1'b0);
    chk("rst_req_ready", up.request_ready, 2'b00);
    chk("rst_rsp_valid", up.response_valid, 2'b00);
    chk("rst_rsp_ready", dn.response_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    up.request_valid  = 2'b00;
    dn.response_valid = 1'b0;

    // single read from master 0
    up.request_valid = 2'b01;
    #1;
    chk("t1_req_valid", dn.request_valid, 1'b1);
    chk("t1_address", dn.address, 64'h1000);
    chk("t1_req_ready", up.request_ready, 2'b01);
    tick();
    up.request_valid = 2'b00;
    #1;
    chk("t1_idle_req_valid", dn.request_valid, 1'b0);
    chk("t1_idle_payload", dn.address, 64'h0);
    dn.response_valid = 1'b1;
    dn.read_data      = 64'hDEAD;
    #1;
    chk("t1_rsp_valid", up.response_valid, 2'b01);
    chk("t1_read_data", up.read_data, 64'hDEAD);
    chk("t1_rsp_ready", dn.response_ready, 1'b1);
    tick();
    // response with FIFO empty is neither delivered nor consumed
    chk("empty_rsp_valid", up.response_valid, 2'b00);
    chk("empty_rsp_ready", dn.response_ready, 1'b0);
    dn.response_valid = 1'b0;

    // round-robin alternation, then FIFO full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    up.request_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), up.request_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_addr%0d", i), dn.address, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      tick();
    end
    chk("full_req_valid", dn.request_valid, 1'b0);
    chk("full_req_ready", up.request_ready, 2'b00);
    dn.response_valid = 1'b1;
    #1;
    chk("full_pop_rsp_valid", up.response_valid, 2'b01);
    chk("full_pop_rsp_ready", dn.response_ready, 1'b1);
    chk("full_pop_still_blocked", dn.request_valid, 1'b0);
    tick();
    dn.response_valid = 1'b0;
    #1;
    chk("after_pop_req_valid", dn.request_valid, 1'b1);
    chk("after_pop_grant", up.request_ready, 2'b01);
    tick();
    up.request_valid  = 2'b00;
    dn.response_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_owner%0d", i), up.response_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    chk("drained_rsp_ready", dn.response_ready, 1'b0);
    dn.response_valid = 1'b0;

    // lock: master 1 stalls while master 0 (favoured by the pointer) arrives
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    up.address       = {64'h3000, 64'h1000};
    up.request_valid = 2'b10;
    dn.request_ready = 1'b0;
    #1;
    chk("lock_c0_valid", dn.request_valid, 1'b1);
    chk("lock_c0_addr", dn.address, 64'h3000);
    chk("lock_c0_ready", up.request_ready, 2'b00);
    tick();
    up.request_valid = 2'b11;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk($sformatf("lock_c%0d_addr", i), dn.address, 64'h3000);
      chk($sformatf("lock_c%0d_ready", i), up.request_ready, 2'b00);
      tick();
    end
    dn.request_ready = 1'b1;
    #1;
    chk("lock_accept_addr", dn.address, 64'h3000);
    chk("lock_accept_ready", up.request_ready, 2'b10);
    tick();
    up.request_valid = 2'b01;
    #1;
    chk("after_lock_addr", dn.address, 64'h1000);
    chk("after_lock_ready", up.request_ready, 2'b01);
    tick();
    up.request_valid  = 2'b00;
    dn.response_valid = 1'b1;
    #1;
    chk("lock_rsp0", up.response_valid, 2'b10);
    tick();
    chk("lock_rsp1", up.response_valid, 2'b01);
    tick();
    dn.response_valid = 1'b0;

    // interleaved m0, m1, m0 then error-tagged responses
    up.write = 2'b10;
    up.request_valid = 2'b01;
    #1;
    chk("il_grant0", up.request_ready, 2'b01);
    chk("il_write0", dn.write, 1'b0);
    tick();
    up.request_valid = 2'b10;
    #1;
    chk("il_grant1", up.request_ready, 2'b10);
    chk("il_write1", dn.write, 1'b1);
    chk("il_strobe1", dn.strobe, 8'hF0);
    chk("il_wdata1", dn.write_data, 64'hBBBB);
    tick();
    up.request_valid = 2'b01;
    #1;
    chk("il_grant2", up.request_ready, 2'b01);
    chk("il_strobe2", dn.strobe, 8'h0F);
    tick();
    up.request_valid  = 2'b00;
    dn.response_valid = 1'b1;
    dn.error          = 1'b0;
    up.response_ready = 2'b10;
    #1;
    chk("stall_rsp_ready", dn.response_ready, 1'b0);
    chk("stall_rsp_valid", up.response_valid, 2'b01);
    tick();
    chk("stall_held_valid", up.response_valid, 2'b01);
    up.response_ready = 2'b11;
    #1;
    chk("il_rsp0_ready", dn.response_ready, 1'b1);
    chk("il_rsp0_error", up.error, 1'b0);
    tick();
    dn.error = 1'b1;
    #1;
    chk("il_rsp1_owner", up.response_valid, 2'b10);
    chk("il_rsp1_error", up.error, 1'b1);
    tick();
    dn.error = 1'b0;
    #1;
    chk("il_rsp2_owner", up.response_valid, 2'b01);
    chk("il_rsp2_error", up.error, 1'b0);
    tick();
    chk("il_empty", up.response_valid, 2'b00);
    dn.response_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
